serial_adder_4bit: RTL

//   Bit-serial adder, the inverse operation of subtractor_4bit: recovers the

---
 rtl/serial_adder_4bit.sv | 98 +++++++++
 1 files changed

// File: rtl/serial_adder_4bit.sv
// serial_adder_4bit: LSB-first bit-serial adder with start/busy/done handshake.
// Optional signed overflow output is enabled by defining SERIAL_ADD_OVF_EN.
// Rev 1.0
`default_nettype none

module serial_adder_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             final_carry
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_sum;
  logic             bit_carry;
  logic [WIDTH-1:0] next_res;

  always_comb begin
    bit_sum   = a_sh[0] ^ b_sh[0] ^ carry;
    bit_carry = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    next_res  = {bit_sum, res_sh[WIDTH-1:1]};
  end

  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      a_sh        <= '0;
      b_sh        <= '0;
      res_sh      <= '0;
      carry       <= 1'b0;
      cnt         <= '0;
      sum         <= '0;
      final_carry <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf         <= 1'b0;
`endif
    end else begin
      case (state)
        S_RUN: begin
          res_sh <= next_res;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= bit_carry;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            sum         <= next_res;
            final_carry <= bit_carry;
`ifdef SERIAL_ADD_OVF_EN
            // On the last bit the shift regs hold the original operand MSBs.
            ovf         <= (a_sh[0] == b_sh[0]) && (bit_sum != a_sh[0]);
`endif
            state       <= S_DONE;
          end
        end
        S_IDLE, S_DONE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
